mem_resp: RTL and testbench
===========================

Name: mem_resp

Overview:
- Responder (memory side) of the byte-wide CPU memory bus: accepts addr / mem_ctrl_wr / wdata from the memory controller and returns rdata.
- Contains a byte RAM that instructions and data share, and a memory-mapped output port.
- Output-port writes go into a TX FIFO, which is drained over a valid/ready byte stream toward the host/UART side.
- Sits between mem_ctrl and the board/simulation top.

Parameters:
- ADDR_WIDTH, 17, RAM address bits; RAM holds 2^ADDR_WIDTH bytes.
- IO_BASE, 32'h00030000, base of the I/O region.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
- WR_HOLD, 2, cycles the initiator holds each write byte on the bus.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk).
- mem_ctrl_wr  in  1  1 = write cycle, 0 = read cycle.
- addr  in  32  byte address.
- wdata  in  8  write byte.
- rdata  out  8  read byte, registered.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data when tx_valid && tx_ready.
- tx_overflow  out  1  sticky flag: a push was dropped because the FIFO was full.

Behaviour:
- Decode:
  - io_sel = addr >= IO_BASE.
  - RAM index = addr[ADDR_WIDTH-1:0] when !io_sel.
  - IO_BASE+0 = TX data register (write-only).
  - IO_BASE+4 = status register.
  - Any other I/O address: reads return 0, writes are ignored.
- Read (mem_ctrl_wr==0), latency 1:
  - rdata <= RAM[index] when !io_sel.
  - rdata <= {5'b0, tx_overflow, full, tx_valid} for the status address.
  - rdata <= 0 for any other I/O address.
  - The value is valid the cycle after addr is presented.
  - RAM read is synchronous; no combinational path from addr to rdata.
- Write (mem_ctrl_wr==1):
  - RAM[index] <= wdata every write cycle when !io_sel. Repeated writes of the same byte are idempotent.
  - rdata holds its previous value during write cycles.
- TX push, deduplicated:
  - hold_cnt counts consecutive cycles with mem_ctrl_wr && addr==IO_BASE.
  - hold_cnt clears to 0 on any other cycle.
  - A push is issued when such a cycle has hold_cnt==0.
  - hold_cnt wraps to 0 after reaching WR_HOLD-1, so back-to-back bytes held WR_HOLD cycles each yield one push per byte.
- TX FIFO:
  - Circular buffer with wr_ptr, rd_ptr and a count of width log2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - full = (count==FIFO_DEPTH).
  - tx_valid = (count!=0).
  - tx_data = mem[rd_ptr], stable while tx_valid && !tx_ready.
- Pop: occurs when tx_valid && tx_ready.
- Simultaneous push and pop:
  - When not empty: both take effect and count is unchanged.
  - When empty: only the push takes effect; tx_valid rises next cycle. There is no fall-through.
  - When full: a pop frees a slot in the same cycle, so the push is accepted and no overflow occurs.
- Push while full without a pop:
  - The byte is dropped.
  - tx_overflow <= 1 and stays set until reset.
- Reset (rst==0 at posedge), including mid-transaction:
  - rdata=0, tx_valid=0, tx_data don't-care, tx_overflow=0.
  - Pointers, count and hold_cnt are cleared; in-flight pushes are discarded.
  - RAM contents are not reset.
- Timing: rdata sampled by the initiator two cycles after it issues addr always sees the read value.

Test Plan:
- RAM read latency:
  - Preload RAM[0x100..0x103] = 13,37,BE,EF.
  - Present addr 0x100, 0x101, 0x102, 0x103, one per 2 cycles, wr=0.
  - Required: rdata shows 13, 37, BE, EF, each one cycle after its addr; rdata is 0 out of reset.
- Store then load:
  - Write 0xA5 to 0x2000, held 2 cycles; then read 0x2000.
  - Required: rdata=A5 next cycle; rdata unchanged during the write cycles.
- TX push dedup:
  - Write bytes 'H','i' to IO_BASE, each held 2 cycles, back-to-back, with tx_ready=0.
  - Required: count=2, tx_data='H'.
  - Then raise tx_ready: 'H' then 'i' on consecutive cycles, then tx_valid=0.
- Full/overflow:
  - With tx_ready=0, push 17 distinct bytes.
  - Required: status read returns 0x03 after 16 bytes; the 17th is dropped; status reads 0x07 and tx_overflow=1.
  - Drain: bytes 0..15 come out in order.
- Push/pop while full:
  - FIFO full and tx_ready=1 in the same cycle as a new push.
  - Required: count stays 16 and tx_overflow stays 0.
- Mid-operation reset:
  - 5 bytes queued plus a partial write hold; assert rst=0 for one cycle.
  - Required: tx_valid=0, rdata=0, status=0x00.
  - A RAM byte written before the reset still reads back correctly.

Source files
------------

// File: rtl/mem_resp_if.sv
// Byte-wide CPU memory bus plus the TX byte stream leaving the responder.
// The master side is the memory controller together with the TX consumer;
// the slave side is the memory responder.
interface mem_resp_if;
  logic        mem_ctrl_wr;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_overflow;

  modport master (
    output mem_ctrl_wr, addr, wdata, tx_ready,
    input  rdata, tx_data, tx_valid, tx_overflow
  );

  modport slave (
    input  mem_ctrl_wr, addr, wdata, tx_ready,
    output rdata, tx_data, tx_valid, tx_overflow
  );
endinterface

// File: rtl/mem_resp.sv
// Memory-side responder: shared byte RAM, a status register and a TX data
// register in the I/O region. TX writes are deduplicated against the
// initiator's multi-cycle write hold and queued in a circular FIFO that
// drains over a valid/ready byte stream.
module mem_resp #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WR_HOLD    = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_resp_if.slave  bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam int unsigned RAM_SZ = 1 << ADDR_WIDTH;

  localparam logic [31:0]       TX_ADDR   = IO_BASE;
  localparam logic [31:0]       STAT_ADDR = IO_BASE + 32'd4;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD - 1);

  // Status byte layout seen by software: bit2 overflow, bit1 full, bit0 data pending.
  function automatic logic [7:0] status_byte(input logic ovf, input logic full_f,
                                             input logic valid_f);
    return {5'b0, ovf, full_f, valid_f};
  endfunction

  // Address decode
  logic                  io_sel;
  logic                  tx_wr;
  logic                  stat_hit;
  logic [ADDR_WIDTH-1:0] ram_idx;

  assign io_sel   = (bus.addr >= IO_BASE);
  assign tx_wr    = bus.mem_ctrl_wr && (bus.addr == TX_ADDR);
  assign stat_hit = (bus.addr == STAT_ADDR);
  assign ram_idx  = bus.addr[ADDR_WIDTH-1:0];

  // Storage (never reset)
  logic [7:0] ram_q  [RAM_SZ];
  logic [7:0] fifo_q [FIFO_DEPTH];

  // Control state
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        rdata_q;

  logic full;
  logic tx_valid;
  logic push;
  logic pop;
  logic push_ok;

  assign full     = (count_q == FULL_CNT);
  assign tx_valid = (count_q != '0);
  assign pop      = tx_valid && bus.tx_ready;
  // Only the first cycle of a held TX write pushes; later hold cycles repeat it.
  assign push     = tx_wr && (hold_cnt_q == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push && (!full || pop);

  // Next-state for hold counter, pointers, occupancy and overflow flag
  always_comb begin
    hold_cnt_d = '0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    if (tx_wr) begin
      hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? '0 : hold_cnt_q + HOLD_W'(1);
    end

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_cnt_q <= hold_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // RAM write port; repeated hold cycles rewrite the same byte harmlessly
  always_ff @(posedge clk) begin
    if (bus.mem_ctrl_wr && !io_sel) begin
      ram_q[ram_idx] <= bus.wdata;
    end
  end

  // FIFO storage write; gated by rst so a reset cycle cannot land a byte
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      fifo_q[wr_ptr_q] <= bus.wdata;
    end
  end

  // Registered read data; holds its value through write cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (!bus.mem_ctrl_wr) begin
      if (!io_sel) begin
        rdata_q <= ram_q[ram_idx];
      end else if (stat_hit) begin
        rdata_q <= status_byte(ovf_q, full, tx_valid);
      end else begin
        rdata_q <= '0;
      end
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.tx_data     = fifo_q[rd_ptr_q];
  assign bus.tx_valid    = tx_valid;
  assign bus.tx_overflow = ovf_q;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp. The driver pushes expected read bytes and
// expected TX bytes into queues as it issues stimulus; a negedge monitor
// pops and compares whenever rdata becomes due or a TX transfer occurs.
module tb_mem_resp;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [31:0] TX_A    = IO_BASE;
  localparam logic [31:0] ST_A    = IO_BASE + 32'd4;
  localparam logic [31:0] IDLE_A  = IO_BASE + 32'd8;

  typedef enum logic [1:0] {K_NONE, K_READ, K_WRITE, K_RESET} kind_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_resp_if bus ();

  mem_resp #(
    .ADDR_WIDTH (17),
    .IO_BASE    (IO_BASE),
    .FIFO_DEPTH (16),
    .WR_HOLD    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] rd_q [$];
  logic [7:0] tx_q [$];
  kind_t      kind      = K_NONE;
  kind_t      prev_kind = K_NONE;
  bit         gap_chk   = 1'b0;
  bit         known     = 1'b0;
  logic [7:0] exp_last  = 8'h00;
  logic [7:0] mv;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: rdata due from the previous cycle's command, and TX transfers
  always @(negedge clk) begin
    case (prev_kind)
      K_RESET: begin
        check8("rst_rdata", bus.rdata, 8'h00);
        check8("rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
        check8("rst_overflow", {7'b0, bus.tx_overflow}, 8'h00);
        exp_last = 8'h00;
        known    = 1'b1;
      end
      K_READ: begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_queue: got read with no expectation at %0t", $time);
        end else begin
          mv = rd_q.pop_front();
          check8("rdata", bus.rdata, mv);
          exp_last = mv;
          known    = 1'b1;
        end
      end
      K_WRITE: begin
        if (known) check8("rdata_hold", bus.rdata, exp_last);
      end
      default: known = 1'b0;
    endcase
    prev_kind = kind;

    if (bus.tx_valid && bus.tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_extra: got byte %02h expected none at %0t", bus.tx_data, $time);
      end else begin
        mv = tx_q.pop_front();
        check8("tx_data", bus.tx_data, mv);
      end
    end else if (gap_chk && bus.tx_ready && tx_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL tx_gap: got tx_valid=0 expected 1 with %0d pending at %0t",
               tx_q.size(), $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wr, input logic [31:0] a, input logic [7:0] d, input kind_t k);
    bus.mem_ctrl_wr = wr;
    bus.addr        = a;
    bus.wdata       = d;
    kind            = k;
    step();
  endtask

  task automatic idle();
    drive(1'b0, IDLE_A, 8'h00, K_NONE);
  endtask

  task automatic wr_byte(input logic [31:0] a, input logic [7:0] d);
    repeat (2) drive(1'b1, a, d, K_WRITE);
  endtask

  task automatic rd_byte(input logic [31:0] a, input logic [7:0] e);
    rd_q.push_back(e);
    drive(1'b0, a, 8'h00, K_READ);
  endtask

  // One reset cycle; bus inputs are left exactly as they were
  task automatic reset_cycle();
    rst  = 1'b0;
    kind = K_RESET;
    step();
    rst  = 1'b1;
  endtask

  task automatic drain(input int cycles);
    bus.tx_ready = 1'b1;
    gap_chk      = 1'b1;
    repeat (cycles) idle();
    gap_chk      = 1'b0;
    bus.tx_ready = 1'b0;
    check8("drain_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    check8("drain_txq_left", 8'(tx_q.size()), 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b0;
    bus.tx_ready    = 1'b0;
    bus.mem_ctrl_wr = 1'b0;
    bus.addr        = IDLE_A;
    bus.wdata       = 8'h00;
    kind            = K_RESET;
    step();
    step();
    rst = 1'b1;
    rd_byte(ST_A, 8'h00);
    idle();

    // RAM read latency
    wr_byte(32'h100, 8'h13);
    wr_byte(32'h101, 8'h37);
    wr_byte(32'h102, 8'hBE);
    wr_byte(32'h103, 8'hEF);
    idle();
    rd_byte(32'h100, 8'h13); idle();
    rd_byte(32'h101, 8'h37); idle();
    rd_byte(32'h102, 8'hBE); idle();
    rd_byte(32'h103, 8'hEF);

    // Store then load; rdata must hold EF through the write
    wr_byte(32'h2000, 8'hA5);
    rd_byte(32'h2000, 8'hA5);
    idle();

    // TX push dedup: two held bytes give exactly two entries
    tx_q.push_back(8'h48);
    wr_byte(TX_A, 8'h48);
    tx_q.push_back(8'h69);
    wr_byte(TX_A, 8'h69);
    idle();
    rd_byte(ST_A, 8'h01);
    idle();
    check8("tx_head", bus.tx_data, 8'h48);
    drain(4);

    // Full and overflow
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'(i));
      wr_byte(TX_A, 8'(i));
    end
    idle();
    rd_byte(ST_A, 8'h03);
    wr_byte(TX_A, 8'h99);
    idle();
    rd_byte(ST_A, 8'h07);
    idle();
    check8("overflow_set", {7'b0, bus.tx_overflow}, 8'h01);
    drain(20);
    rd_byte(ST_A, 8'h04);
    idle();

    // Push and pop in the same cycle while full
    reset_cycle();
    idle();
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'h20 + 8'(i));
      wr_byte(TX_A, 8'h20 + 8'(i));
    end
    idle();
    tx_q.push_back(8'h30);
    bus.tx_ready = 1'b1;
    drive(1'b1, TX_A, 8'h30, K_WRITE);
    bus.tx_ready = 1'b0;
    drive(1'b1, TX_A, 8'h30, K_WRITE);
    idle();
    rd_byte(ST_A, 8'h03);
    idle();
    check8("pushpop_overflow", {7'b0, bus.tx_overflow}, 8'h00);
    drain(20);

    // Mid-operation reset with queued bytes and a partial write hold
    wr_byte(32'h3000, 8'h5A);
    for (int i = 0; i < 5; i++) wr_byte(TX_A, 8'h40 + 8'(i));
    rd_byte(32'h3000, 8'h5A);
    drive(1'b1, TX_A, 8'h77, K_WRITE);
    reset_cycle();
    idle();
    check8("post_rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    rd_byte(ST_A, 8'h00);
    rd_byte(32'h3000, 8'h5A);
    idle();
    idle();

    check8("rdq_left", 8'(rd_q.size()), 8'h00);
    check8("txq_left", 8'(tx_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
